// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per clock over SIZE cycles,
// with the partial sum formed by a single generate/propagate carry-lookahead adder.

module cl_adder #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            c_in,
    output logic [SIZE-1:0] sum,
    output logic            c_out
);

    logic [SIZE-1:0] gen_s;
    logic [SIZE-1:0] prop_s;

    // Per-bit generate/propagate terms, then carries resolved from them LSB-first
    always_comb begin
        logic carry_v;
        gen_s   = a & b;
        prop_s  = a ^ b;
        carry_v = c_in;
        sum     = {SIZE{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            sum[i]  = prop_s[i] ^ carry_v;
            carry_v = gen_s[i] | (prop_s[i] & carry_v);
        end
        c_out = carry_v;
    end

endmodule

module shift_add_multiplier #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [SIZE-1:0]   mcand_r;
    logic [2*SIZE-1:0] acc_r;
    logic [CW-1:0]     count_r;
    logic [2*SIZE-1:0] product_r;
    logic              busy_r;
    logic              done_r;

    logic [SIZE-1:0]   sum_s;
    logic              c_out_s;
    logic [2*SIZE-1:0] acc_step_s;
    logic              last_s;
    logic              load_s;
    logic              step_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;

    cl_adder #(.SIZE(SIZE)) u_adder (
        .a     (acc_r[2*SIZE-1:SIZE]),
        .b     (mcand_r),
        .c_in  (1'b0),
        .sum   (sum_s),
        .c_out (c_out_s)
    );

    assign last_s = (count_r == CW'(SIZE - 1));

    // One multiply step: add multiplicand into the upper half when the LSB is set,
    // then shift right keeping the adder carry as the new MSB
    always_comb begin
        if (acc_r[0]) begin
            acc_step_s = {c_out_s, sum_s, acc_r[SIZE-1:1]};
        end else begin
            acc_step_s = {1'b0, acc_r[2*SIZE-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; CALC always runs the full SIZE steps
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output/control decode; busy and done are computed one cycle ahead and registered
    always_comb begin
        load_s     = 1'b0;
        step_s     = 1'b0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s     = start;
                busy_nxt_s = start;
            end
            CALC: begin
                step_s     = 1'b1;
                busy_nxt_s = 1'b1;
                done_nxt_s = last_s;
            end
            DONE: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= {SIZE{1'b0}};
            acc_r     <= {(2*SIZE){1'b0}};
            count_r   <= {CW{1'b0}};
            product_r <= {(2*SIZE){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (load_s) begin
                mcand_r <= a;
                acc_r   <= {{SIZE{1'b0}}, b};
                count_r <= {CW{1'b0}};
            end else if (step_s) begin
                acc_r   <= acc_step_s;
                count_r <= count_r + CW'(1);
                if (last_s) begin
                    product_r <= acc_step_s;
                end
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: SIZE, default 32, operand width in bits (legal range 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-005 a  input  SIZE  multiplicand, unsigned; sampled on the accepting edge only.
REQ-006 b  input  SIZE  multiplier, unsigned; sampled on the accepting edge only.
REQ-007 busy  output  1  high while in CALC or DONE.
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  2*SIZE  registered unsigned product, held until next completion.

Function
REQ-010 The partial-sum add SHALL use one cl_adder #(SIZE) instance, upper accumulator half plus latched multiplicand, with its c_out as the carry; no other adder on the datapath.
REQ-011 State machine SHALL have exactly IDLE, CALC, DONE.
REQ-012 IDLE: if start=1 at an edge, latch mcand<=a, acc<={SIZE zeros, b}, count<=0, go CALC; else stay.
REQ-013 CALC step per edge: if acc[0]=1, acc <= {c_out, sum, acc[SIZE-1:1]}, where sum/c_out = acc[2*SIZE-1:SIZE] + mcand; else acc <= {1'b0, acc[2*SIZE-1:1]}.
REQ-014 count SHALL increment each CALC edge; on the edge where count==SIZE-1, the final step is performed, product <= stepped acc, state -> DONE.
REQ-015 CALC SHALL last exactly SIZE cycles regardless of operand values (no early exit on zero bits).
REQ-016 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-017 Latency: with start accepted at edge k, done=1 in the cycle following edge k+SIZE; earliest next acceptance is edge k+SIZE+2.
REQ-018 start while busy=1 (CALC or DONE) SHALL be ignored, with no effect on state, operands or product.
REQ-019 Changes on a/b after acceptance SHALL not affect the running product.
REQ-020 product SHALL be exact: a*b modulo 2^(2*SIZE), i.e. always exact since max product < 2^(2*SIZE); c_out of each step SHALL never be discarded.
REQ-021 product SHALL change only on the final CALC edge or on reset; done and busy SHALL be registered outputs with no combinational path from start.
REQ-022 count width SHALL be ceil(log2(SIZE)) bits minimum with no wrap before SIZE-1 compare.

Reset
REQ-023 rst=1 at an edge SHALL force state=IDLE, busy=0, done=0, product=0, count=0, acc=0, mcand=0.
REQ-024 rst SHALL take priority over start in the same cycle; start asserted with rst is not accepted.
REQ-025 rst during CALC or DONE SHALL abort the operation; no done pulse is issued for it, and product reads 0.
REQ-026 First start accepted on the first edge after rst deasserts SHALL proceed normally.

Verification
REQ-027 SIZE=32, a=6, b=5, start one cycle -> busy high 33 cycles, done single pulse 32 edges after acceptance, product=30.
REQ-028 SIZE=32, a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (exercises c_out every step).
REQ-029 SIZE=32, a=0x12345678, b=0 and a=0, b=0xDEADBEEF -> product=0, latency still 32 cycles.
REQ-030 Start pulsed again during CALC with a=9, b=9 after a=3, b=7 accepted -> single done, product=21; start in DONE cycle also ignored.
REQ-031 rst asserted at CALC cycle 10 of a=8, b=9 -> busy=0, done never pulses, product=0; next start a=1, b=4 -> product=4.
REQ-032 SIZE=4 build, all 256 (a,b) pairs back-to-back at the earliest acceptance edge -> each product equals a*b, 4-cycle CALC each.
